// File: rtl/cute_lock_key_sequencer_pkg.sv
// Shared constants and FSM state type for the time-varying key interface.
// Locked cores import the same constants so their key-window period matches.
package cute_lock_key_sequencer_pkg;

    localparam int unsigned DEF_KEY_W     = 5;
    localparam int unsigned DEF_NUM_KEYS  = 2;
    localparam int unsigned DEF_PHASE_LEN = 5;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        ARMED,
        ACTIVE
    } seq_state_t;

endpackage

// File: rtl/cute_lock_key_sequencer_phase_counter.sv
// Free-running key-window counter (0..PERIOD-1) with phase = counter / PHASE_LEN.
// Also exports the phase of the upcoming count so registered consumers stay aligned.
module cute_lock_phase_counter
    import cute_lock_key_sequencer_pkg::*;
#(
    parameter int unsigned NUM_KEYS  = DEF_NUM_KEYS,
    parameter int unsigned PHASE_LEN = DEF_PHASE_LEN
) (
    input  logic                                     clk,
    input  logic                                     rst,
    output logic [$clog2(NUM_KEYS*PHASE_LEN)-1:0]    counter,
    output logic [$clog2(NUM_KEYS)-1:0]              phase,
    output logic [$clog2(NUM_KEYS)-1:0]              phase_nxt,
    output logic                                     wrap
);

    localparam int unsigned PERIOD = NUM_KEYS * PHASE_LEN;
    localparam int unsigned CW     = $clog2(PERIOD);
    localparam int unsigned PW     = $clog2(NUM_KEYS);

    logic [CW-1:0] counter_nxt;

    // Phase boundaries are constant, so a compare chain replaces the divider.
    function automatic logic [PW-1:0] phase_of(input logic [CW-1:0] c);
        phase_of = '0;
        for (int unsigned k = 1; k < NUM_KEYS; k++) begin
            if (c >= CW'(k * PHASE_LEN)) begin
                phase_of = PW'(k);
            end
        end
    endfunction

    always_comb begin
        wrap        = (counter == CW'(PERIOD - 1));
        counter_nxt = wrap ? '0 : counter + CW'(1);
        phase       = phase_of(counter);
        phase_nxt   = phase_of(counter_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
        end else begin
            counter <= counter_nxt;
        end
    end

endmodule

// File: rtl/cute_lock_key_sequencer.sv
// Key-delivery sequencer: loads a serial key set into a shadow, commits it on a
// period boundary and drives one key per counter phase onto keyinput.
module cute_lock_key_sequencer
    import cute_lock_key_sequencer_pkg::*;
#(
    parameter int unsigned KEY_W     = DEF_KEY_W,
    parameter int unsigned NUM_KEYS  = DEF_NUM_KEYS,
    parameter int unsigned PHASE_LEN = DEF_PHASE_LEN
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     zeroize,
    input  logic                                     ld_valid,
    input  logic                                     ld_bit,
    output logic                                     ld_ready,
    output logic [KEY_W-1:0]                         keyinput,
    output logic                                     key_active,
    output logic [$clog2(NUM_KEYS)-1:0]              phase,
    output logic [$clog2(NUM_KEYS*PHASE_LEN)-1:0]    counter
);

    localparam int unsigned TOTAL = NUM_KEYS * KEY_W;
    localparam int unsigned PW    = $clog2(NUM_KEYS);

    typedef logic [NUM_KEYS-1:0][KEY_W-1:0] keyset_t;

    seq_state_t        state, state_n;
    logic [TOTAL-1:0]  shadow, shadow_n;
    logic [TOTAL-1:0]  pos, pos_n;
    keyset_t           active, active_n;
    logic              key_active_n;
    logic [KEY_W-1:0]  keyinput_n;
    logic [PW-1:0]     phase_nxt;
    logic              wrap;
    logic              accept;

    cute_lock_phase_counter #(
        .NUM_KEYS  (NUM_KEYS),
        .PHASE_LEN (PHASE_LEN)
    ) u_phase_counter (
        .clk       (clk),
        .rst       (rst),
        .counter   (counter),
        .phase     (phase),
        .phase_nxt (phase_nxt),
        .wrap      (wrap)
    );

    always_comb begin
        ld_ready     = !zeroize;
        accept       = ld_valid && ld_ready;
        state_n      = state;
        shadow_n     = shadow;
        pos_n        = pos;
        active_n     = active;
        key_active_n = key_active;

        if (zeroize) begin
            state_n      = EMPTY;
            shadow_n     = '0;
            pos_n        = TOTAL'(1);
            active_n     = '0;
            key_active_n = 1'b0;
        end else begin
            case (state)
                EMPTY, LOADING: begin
                    if (accept) begin
                        // pos is a one-hot write pointer into the flat shadow.
                        for (int unsigned i = 0; i < TOTAL; i++) begin
                            if (pos[i]) begin
                                shadow_n[i] = ld_bit;
                            end
                        end
                        pos_n   = pos << 1;
                        state_n = pos[TOTAL-1] ? ARMED : LOADING;
                    end
                end
                ARMED, ACTIVE: begin
                    if (state == ARMED && wrap) begin
                        active_n     = keyset_t'(shadow);
                        key_active_n = 1'b1;
                        state_n      = ACTIVE;
                    end
                    // Commit (if any) has already taken the old shadow; restart at bit 0.
                    if (accept) begin
                        shadow_n = {{(TOTAL-1){1'b0}}, ld_bit};
                        pos_n    = TOTAL'(2);
                        state_n  = LOADING;
                    end
                end
                default: begin
                    state_n = EMPTY;
                end
            endcase
        end

        keyinput_n = key_active_n ? active_n[phase_nxt] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            shadow     <= '0;
            pos        <= TOTAL'(1);
            active     <= '0;
            key_active <= 1'b0;
            keyinput   <= '0;
        end else begin
            state      <= state_n;
            shadow     <= shadow_n;
            pos        <= pos_n;
            active     <= active_n;
            key_active <= key_active_n;
            keyinput   <= keyinput_n;
        end
    end

endmodule

// File: tb/tb_cute_lock_key_sequencer.sv
// Self-checking bench: abstract queue-based model checked every cycle,
// plus directed literal checks of the documented key schedule.
module tb_cute_lock_key_sequencer;

    localparam int unsigned KEY_W     = 5;
    localparam int unsigned NUM_KEYS  = 2;
    localparam int unsigned PHASE_LEN = 5;
    localparam int unsigned PERIOD    = NUM_KEYS * PHASE_LEN;
    localparam int unsigned TOTAL     = NUM_KEYS * KEY_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zeroize = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_bit = 1'b0;
    logic       ld_ready;
    logic [4:0] keyinput;
    logic       key_active;
    logic [0:0] phase;
    logic [3:0] counter;

    int checks = 0;
    int errors = 0;

    cute_lock_key_sequencer #(
        .KEY_W     (KEY_W),
        .NUM_KEYS  (NUM_KEYS),
        .PHASE_LEN (PHASE_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .zeroize    (zeroize),
        .ld_valid   (ld_valid),
        .ld_bit     (ld_bit),
        .ld_ready   (ld_ready),
        .keyinput   (keyinput),
        .key_active (key_active),
        .phase      (phase),
        .counter    (counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counter as an integer, received bits in a queue,
    // a completed set waits as "pending" until a period boundary.
    int         mcnt = 0;
    bit         mact = 0;
    bit         pend = 0;
    bit         ld_q[$];
    logic [4:0] mkey [NUM_KEYS];
    logic [4:0] pkey [NUM_KEYS];
    bit         started = 0;
    bit         commit_now;
    bit         acc_now;

    always @(posedge clk) begin
        if (rst) begin
            mcnt = 0; mact = 0; pend = 0; ld_q.delete();
            started = 1;
        end else begin
            commit_now = pend && (mcnt == PERIOD - 1);
            acc_now    = ld_valid && !zeroize;
            mcnt       = (mcnt + 1) % PERIOD;
            if (zeroize) begin
                mact = 0; pend = 0; ld_q.delete();
            end else begin
                if (commit_now) begin
                    mkey = pkey; mact = 1; pend = 0;
                end
                if (acc_now) begin
                    pend = 0;
                    ld_q.push_back(ld_bit);
                    if (ld_q.size() == TOTAL) begin
                        for (int k = 0; k < NUM_KEYS; k++)
                            for (int b = 0; b < KEY_W; b++)
                                pkey[k][b] = ld_q[k*KEY_W + b];
                        pend = 1;
                        ld_q.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("counter",    int'(counter),    mcnt);
            chk("phase",      int'(phase),      mcnt / PHASE_LEN);
            chk("key_active", int'(key_active), int'(mact));
            chk("keyinput",   int'(keyinput),   mact ? int'(mkey[mcnt / PHASE_LEN]) : 0);
            chk("ld_ready",   int'(ld_ready),   int'(!zeroize));
        end
    end

    task automatic cyc(input logic v, input logic b, input logic z);
        ld_valid = v; ld_bit = b; zeroize = z;
        @(posedge clk);
        #2;
        ld_valid = 1'b0; zeroize = 1'b0;
    endtask

    task automatic load(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, bits[i], 1'b0);
    endtask

    task automatic wait_cnt(input int c);
        int guard = 0;
        while (int'(counter) != c && guard < 2 * PERIOD) begin
            cyc(1'b0, 1'b0, 1'b0);
            guard++;
        end
        if (int'(counter) != c) chk("wait_cnt_timeout", int'(counter), c);
    endtask

    // Stream 1,0,0,0,1,1,1,0,1,0 -> key0 = 10001, key1 = 01011
    localparam logic [9:0] SET_A = 10'b0101110001;
    localparam logic [9:0] SET_B = 10'b1010100110;

    initial begin
        // Test 1: reset, idle for 25 cycles
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_counter", int'(counter), 0);
        chk("rst_keyinput", int'(keyinput), 0);
        chk("rst_key_active", int'(key_active), 0);
        chk("rst_ld_ready", int'(ld_ready), 1);
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("idle_key_active", int'(key_active), 0);

        // Test 2: first load, commit at next wrap
        load(SET_A, 10);
        chk("armed_not_active", int'(key_active), 0);
        wait_cnt(9);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t2_active", int'(key_active), 1);
        chk("t2_key0", int'(keyinput), 5'b10001);
        wait_cnt(5);
        chk("t2_key1", int'(keyinput), 5'b01011);

        // Test 3: reload mid-period while active; old keys hold until next wrap
        wait_cnt(3);
        load(SET_B, 10);
        wait_cnt(9);
        chk("t3_old_key1", int'(keyinput), 5'b01011);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_new_key0", int'(keyinput), 5'b00110);
        wait_cnt(5);
        chk("t3_new_key1", int'(keyinput), 5'b10101);

        // Test 4: zeroize mid-load with ld_valid high
        load(SET_A, 4);
        ld_valid = 1'b1; ld_bit = 1'b1; zeroize = 1'b1;
        #1;
        chk("t4_ld_ready_low", int'(ld_ready), 0);
        @(posedge clk);
        #2;
        ld_valid = 1'b0; zeroize = 1'b0;
        chk("t4_key_active", int'(key_active), 0);
        chk("t4_keyinput", int'(keyinput), 0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("t4_still_empty", int'(key_active), 0);

        // Test 5: last bit on the counter=9 edge -> commit one full period later
        wait_cnt(0);
        load(SET_A, 10);
        chk("t5_cnt_after_load", int'(counter), 0);
        chk("t5_not_yet", int'(key_active), 0);
        wait_cnt(9);
        chk("t5_not_yet_9", int'(key_active), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t5_active", int'(key_active), 1);
        chk("t5_key0", int'(keyinput), 5'b10001);

        // Test 6: reset after 6 bits, then a full load
        load(10'b1111111111, 6);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t6_rst_active", int'(key_active), 0);
        chk("t6_rst_counter", int'(counter), 0);
        load(SET_A, 10);
        wait_cnt(9);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_key0", int'(keyinput), 5'b10001);
        wait_cnt(5);
        chk("t6_key1", int'(keyinput), 5'b01011);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
